// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder with all four CPOL/CPHA modes, 8-bit MSb-first frames and
// back-to-back bytes inside one chip-select assertion. The SPI pins are
// asynchronous to clk and are oversampled through 2-FF synchronizers, so the
// system clock must run at least 8x the SPI clock.
//
// Parameters:
//   CPOL      SCLK idle level
//   CPHA      0: sample on leading edge, shift on trailing edge
//             1: shift on leading edge, sample on trailing edge
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-low
//   sclk      SPI clock from the master (asynchronous)
//   cs        chip select, active-low (asynchronous)
//   mosi      serial data from the master (asynchronous)
//   miso      serial data to the master (bit 7 of the transmit shifter)
//   miso_oe   miso output enable, high while selected
//   tx_data   byte to transmit, captured when tx_ack pulses
//   tx_ack    1-cycle pulse: tx_data captured, next byte may be presented
//   rx_data   last complete received byte
//   rx_valid  1-cycle pulse: rx_data updated
//   busy      high while a frame is active
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter logic CPOL = 1'b0,
    parameter logic CPHA = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Sampling happens on the rising sclk edge in modes 0 and 3.
    localparam logic SAMPLE_ON_RISE = ~(CPOL ^ CPHA);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizers plus one delay stage on sclk/cs for edge detection
    // -------------------------------------------------------------------------
    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_d  <= CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic sclk_rise_c, sclk_fall_c;
    logic sample_edge_c, shift_edge_c;
    logic cs_fall_c, cs_rise_c;

    // Edge strobes, one clk wide, in the synchronized domain.
    always_comb begin
        sclk_rise_c   = sclk_s2 & ~sclk_d;
        sclk_fall_c   = ~sclk_s2 & sclk_d;
        sample_edge_c = SAMPLE_ON_RISE ? sclk_rise_c : sclk_fall_c;
        shift_edge_c  = SAMPLE_ON_RISE ? sclk_fall_c : sclk_rise_c;
        cs_fall_c     = ~cs_s2 & cs_d;
        cs_rise_c     = cs_s2 & ~cs_d;
    end

    // -------------------------------------------------------------------------
    // Frame FSM: state and datapath registers
    // -------------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [DATA_W-1:0]   tx_sr, tx_sr_nxt;
    logic [DATA_W-1:0]   rx_sr, rx_sr_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                byte_done, byte_done_nxt;
    logic [DATA_W-1:0]   rx_data_nxt;
    logic                rx_valid_nxt;
    logic                tx_ack_nxt;
    logic                miso_nxt;
    logic                busy_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ack    <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_sr     <= tx_sr_nxt;
            rx_sr     <= rx_sr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_done <= byte_done_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_ack    <= tx_ack_nxt;
            miso      <= miso_nxt;
            miso_oe   <= busy_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        tx_sr_nxt     = tx_sr;
        rx_sr_nxt     = rx_sr;
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = 1'b0;
        tx_ack_nxt    = 1'b0;

        unique case (state)
            // sclk edges are ignored while deselected, including one that
            // coincides with the cs falling edge.
            IDLE: begin
                if (cs_fall_c) begin
                    tx_sr_nxt     = tx_data;
                    tx_ack_nxt    = 1'b1;
                    bit_cnt_nxt   = '0;
                    byte_done_nxt = 1'b0;
                    state_nxt     = ACTIVE;
                end
            end

            ACTIVE: begin
                if (cs_rise_c) begin
                    // Deselect wins over any same-cycle sclk edge; a partial
                    // byte is dropped without touching rx_data.
                    bit_cnt_nxt   = '0;
                    byte_done_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (sample_edge_c) begin
                    rx_sr_nxt   = {rx_sr[DATA_W-2:0], mosi_s2};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        rx_data_nxt   = {rx_sr[DATA_W-2:0], mosi_s2};
                        rx_valid_nxt  = 1'b1;
                        byte_done_nxt = 1'b1;
                    end
                end else if (shift_edge_c) begin
                    if (byte_done) begin
                        // Reload on the shift edge after the last sample so
                        // bit 7 of the next byte leads the next sample edge.
                        tx_sr_nxt     = tx_data;
                        tx_ack_nxt    = 1'b1;
                        byte_done_nxt = 1'b0;
                    end else if (CPHA && (bit_cnt == '0)) begin
                        // First leading edge of a CPHA=1 frame: bit 7 is
                        // already on miso, so keep it there.
                        tx_sr_nxt = tx_sr;
                    end else begin
                        tx_sr_nxt = {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ACTIVE);
        miso_nxt = busy_nxt ? tx_sr_nxt[DATA_W-1] : 1'b0;
    end

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Four spi_slave instances, one per SPI mode (instance index = {CPOL,CPHA}),
// each with its own sclk/cs/tx_data. A master task drives one instance at a
// time. Expected received bytes are queued per instance when a byte is
// issued; a monitor pops and compares on every rx_valid pulse.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int unsigned N_INST = 4;
    localparam int unsigned HALF   = 8;   // sclk half period in clk cycles

    logic       clk;
    logic       rst;
    logic       mosi;
    logic       sclk_w     [N_INST];
    logic       cs_w       [N_INST];
    logic [7:0] tx_data_w  [N_INST];
    logic       miso_w     [N_INST];
    logic       miso_oe_w  [N_INST];
    logic       tx_ack_w   [N_INST];
    logic [7:0] rx_data_w  [N_INST];
    logic       rx_valid_w [N_INST];
    logic       busy_w     [N_INST];

    int         checks;
    int         failures;
    int         ack_cnt [N_INST];
    logic [7:0] exp_q   [N_INST][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        localparam logic [1:0] MD = 2'(g);
        spi_slave #(
            .CPOL(MD[1]),
            .CPHA(MD[0])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .sclk    (sclk_w[g]),
            .cs      (cs_w[g]),
            .mosi    (mosi),
            .miso    (miso_w[g]),
            .miso_oe (miso_oe_w[g]),
            .tx_data (tx_data_w[g]),
            .tx_ack  (tx_ack_w[g]),
            .rx_data (rx_data_w[g]),
            .rx_valid(rx_valid_w[g]),
            .busy    (busy_w[g])
        );
    end

    // Scoreboard monitor: count tx_ack pulses, check every rx_valid.
    always @(negedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (tx_ack_w[i]) ack_cnt[i]++;
            if (rx_valid_w[i]) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    failures++;
                    $display("FAIL rx_unexpected inst=%0d got=%h required=none", i, rx_data_w[i]);
                end else begin
                    logic [7:0] e;
                    e = exp_q[i].pop_front();
                    if (rx_data_w[i] !== e) begin
                        failures++;
                        $display("FAIL rx_byte inst=%0d got=%h required=%h", i, rx_data_w[i], e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h required=%h", name, idx, got, exp);
        end
    endtask

    task automatic wait_ack(input int idx, input int target);
        int k;
        k = 0;
        while (ack_cnt[idx] < target && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("tx_ack_at_cs_fall", idx, 8'(ack_cnt[idx]), 8'(target));
    endtask

    // Master side of nb bits, MSb first, in the mode of instance idx.
    task automatic xfer(input int idx, input logic [7:0] b, input int nb, output logic [7:0] r);
        logic [1:0] md;
        md = 2'(idx);
        r  = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!md[0]) begin
                mosi = b[i];
                repeat (HALF) @(negedge clk);
                r[i] = miso_w[idx];
                sclk_w[idx] = ~md[1];
                repeat (HALF) @(negedge clk);
                sclk_w[idx] = md[1];
            end else begin
                sclk_w[idx] = ~md[1];
                mosi = b[i];
                repeat (HALF) @(negedge clk);
                r[i] = miso_w[idx];
                sclk_w[idx] = md[1];
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic deselect(input int idx);
        repeat (HALF) @(negedge clk);
        cs_w[idx] = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_after_cs_rise", idx, 8'(busy_w[idx]), 8'h00);
        chk("miso_oe_after_cs_rise", idx, 8'(miso_oe_w[idx]), 8'h00);
    endtask

    // Full frame of n (1 or 2) bytes; t1 is presented after the cs-fall ack.
    task automatic frame(input int idx, input int n, input logic [7:0] m0, input logic [7:0] m1,
                         input logic [7:0] t0, input logic [7:0] t1);
        int         base;
        logic [7:0] r;
        logic [1:0] md;
        md   = 2'(idx);
        base = ack_cnt[idx];
        tx_data_w[idx] = t0;
        @(negedge clk);
        cs_w[idx] = 1'b0;
        wait_ack(idx, base + 1);
        chk("busy_in_frame", idx, 8'(busy_w[idx]), 8'h01);
        chk("miso_oe_in_frame", idx, 8'(miso_oe_w[idx]), 8'h01);
        if (n > 1) tx_data_w[idx] = t1;
        repeat (HALF) @(negedge clk);
        exp_q[idx].push_back(m0);
        xfer(idx, m0, 8, r);
        chk("master_rx_byte0", idx, r, t0);
        if (n > 1) begin
            exp_q[idx].push_back(m1);
            xfer(idx, m1, 8, r);
            chk("master_rx_byte1", idx, r, t1);
        end
        deselect(idx);
        // CPHA=0 reloads after every byte's final trailing edge; CPHA=1
        // reloads on the leading edge of each following byte.
        chk("tx_ack_count", idx, 8'(ack_cnt[idx] - base), 8'(md[0] ? n : n + 1));
    endtask

    initial begin
        logic [7:0] r;
        int         base;
        checks   = 0;
        failures = 0;
        mosi     = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            logic [1:0] md;
            md           = 2'(i);
            sclk_w[i]    = md[1];
            cs_w[i]      = 1'b1;
            tx_data_w[i] = 8'h00;
            ack_cnt[i]   = 0;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            chk("reset_miso", i, 8'(miso_w[i]), 8'h00);
            chk("reset_miso_oe", i, 8'(miso_oe_w[i]), 8'h00);
            chk("reset_busy", i, 8'(busy_w[i]), 8'h00);
            chk("reset_tx_ack", i, 8'(tx_ack_w[i]), 8'h00);
            chk("reset_rx_data", i, rx_data_w[i], 8'h00);
            chk("reset_rx_valid", i, 8'(rx_valid_w[i]), 8'h00);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 single byte: master gets A5, slave gets 3C.
        frame(0, 1, 8'h3C, 8'h00, 8'hA5, 8'h00);
        chk("rx_data_hold", 0, rx_data_w[0], 8'h3C);

        // Modes 1..3: master gets 81, slave gets 7E.
        for (int i = 1; i < N_INST; i++) begin
            frame(i, 1, 8'h7E, 8'h00, 8'h81, 8'h00);
            chk("rx_data_mode", i, rx_data_w[i], 8'h7E);
        end

        // Mode 0 back-to-back bytes in one frame.
        frame(0, 2, 8'hDE, 8'hAD, 8'h12, 8'h34);
        chk("rx_data_b2b", 0, rx_data_w[0], 8'hAD);

        // Abort after 5 bits: nothing received, rx_data kept.
        tx_data_w[0] = 8'h00;
        @(negedge clk);
        cs_w[0] = 1'b0;
        repeat (HALF + 4) @(negedge clk);
        xfer(0, 8'hFF, 5, r);
        deselect(0);
        chk("rx_data_after_abort", 0, rx_data_w[0], 8'hAD);
        frame(0, 1, 8'h55, 8'h00, 8'h00, 8'h00);
        chk("rx_data_after_abort_frame", 0, rx_data_w[0], 8'h55);

        // Synchronous reset in the middle of a byte.
        tx_data_w[0] = 8'hFF;
        @(negedge clk);
        cs_w[0] = 1'b0;
        repeat (HALF + 4) @(negedge clk);
        xfer(0, 8'hF0, 4, r);
        rst     = 1'b0;
        cs_w[0] = 1'b1;
        @(negedge clk);
        chk("rst_busy", 0, 8'(busy_w[0]), 8'h00);
        chk("rst_miso_oe", 0, 8'(miso_oe_w[0]), 8'h00);
        chk("rst_rx_data", 0, rx_data_w[0], 8'h00);
        chk("rst_rx_valid", 0, 8'(rx_valid_w[0]), 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        base = ack_cnt[0];
        for (int k = 0; k < 6; k++) begin
            sclk_w[0] = ~sclk_w[0];
            mosi      = ~mosi;
            repeat (HALF) @(negedge clk);
            chk("idle_busy", 0, 8'(busy_w[0]), 8'h00);
            chk("idle_miso", 0, 8'(miso_w[0]), 8'h00);
            chk("idle_miso_oe", 0, 8'(miso_oe_w[0]), 8'h00);
            chk("idle_rx_data", 0, rx_data_w[0], 8'h00);
        end
        chk("idle_tx_ack_count", 0, 8'(ack_cnt[0] - base), 8'h00);

        // cs fall coinciding with a sampling sclk edge: that edge is ignored.
        tx_data_w[0] = 8'hC3;
        exp_q[0].push_back(8'h0F);
        @(negedge clk);
        mosi      = 1'b1;
        cs_w[0]   = 1'b0;
        sclk_w[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("coincident_busy", 0, 8'(busy_w[0]), 8'h01);
        chk("coincident_rx_valid", 0, 8'(rx_valid_w[0]), 8'h00);
        repeat (HALF - 4) @(negedge clk);
        sclk_w[0] = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer(0, 8'h0F, 8, r);
        deselect(0);
        chk("rx_data_coincident", 0, rx_data_w[0], 8'h0F);

        repeat (4) @(negedge clk);
        for (int i = 0; i < N_INST; i++)
            chk("rx_missing", i, 8'(exp_q[i].size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
